// File: rtl/pool1_max2x2.sv
// pool1_max2x2: 2x2 stride-2 pooling stage that sits after the first convolution.
// Consumes a valid-qualified IN_ROWS x IN_COLS raster (row-major) and emits an
// (IN_ROWS/2) x (IN_COLS/2) raster with one-cycle valid strobes.
// A single line buffer of IN_COLS/2 entries holds the horizontal results of the
// even row until the odd row completes each window.
// Build option: define POOL1_AVG_EN for average pooling (truncating); the default
// build performs unsigned max pooling.
module pool1_max2x2 #(
    parameter int DATA_W  = 32,
    parameter int IN_COLS = 24,
    parameter int IN_ROWS = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] pool_data_in,
    input  logic              pool_data_in_valid,
    input  logic              img_in_en,
    output logic [DATA_W-1:0] pool_data_out,
    output logic              pool_data_out_valid,
    output logic              frame_done
);

    localparam int COL_W   = $clog2(IN_COLS);
    localparam int ROW_W   = $clog2(IN_ROWS);
    localparam int HALF    = IN_COLS / 2;
    localparam int IDX_W   = COL_W - 1;

`ifdef POOL1_AVG_EN
    // Horizontal stage keeps the full pair sum so the vertical add cannot overflow.
    localparam int LB_W = DATA_W + 1;

    function automatic logic [LB_W-1:0] horiz_op(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic [DATA_W-1:0] vert_op(input logic [LB_W-1:0] a,
                                                  input logic [LB_W-1:0] b);
        logic [DATA_W+1:0] total;
        total = {1'b0, a} + {1'b0, b};
        return DATA_W'(total >> 2);
    endfunction
`else
    localparam int LB_W = DATA_W;

    function automatic logic [LB_W-1:0] horiz_op(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        return (a >= b) ? a : b;
    endfunction

    function automatic logic [DATA_W-1:0] vert_op(input logic [LB_W-1:0] a,
                                                  input logic [LB_W-1:0] b);
        return (a >= b) ? a : b;
    endfunction
`endif

    logic [COL_W-1:0]  col_cnt;
    logic [ROW_W-1:0]  row_cnt;
    logic [DATA_W-1:0] pair_reg;
    logic [LB_W-1:0]   line_buf [HALF];

    logic              acc_p0;
    logic              last_col_p0;
    logic              last_row_p0;
    logic [IDX_W-1:0]  lb_idx_p0;
    logic [LB_W-1:0]   h_p0;
    logic [DATA_W-1:0] res_p0;

    logic [DATA_W-1:0] data_p1;
    logic              vld_p1;
    logic              done_p1;

    // Stage p0: accept, position decode and combinational window reduction.
    always_comb begin
        acc_p0      = pool_data_in_valid & img_in_en;
        last_col_p0 = (col_cnt == COL_W'(IN_COLS - 1));
        last_row_p0 = (row_cnt == ROW_W'(IN_ROWS - 1));
        lb_idx_p0   = col_cnt[COL_W-1:1];
        h_p0        = horiz_op(pair_reg, pool_data_in);
        res_p0      = vert_op(h_p0, line_buf[lb_idx_p0]);
    end

    // Position counters and the even-column pair register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_cnt  <= '0;
            row_cnt  <= '0;
            pair_reg <= '0;
        end else if (!img_in_en) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (acc_p0) begin
            if (last_col_p0) begin
                col_cnt <= '0;
                row_cnt <= last_row_p0 ? '0 : row_cnt + 1'b1;
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
            if (!col_cnt[0]) begin
                pair_reg <= pool_data_in;
            end
        end
    end

    // Line buffer: even rows park their horizontal result; never read before written.
    always_ff @(posedge clk) begin
        if (acc_p0 && col_cnt[0] && !row_cnt[0]) begin
            line_buf[lb_idx_p0] <= h_p0;
        end
    end

    // Stage p1: register the completed window; valid and frame_done are one-cycle strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
            done_p1 <= 1'b0;
        end else begin
            vld_p1  <= 1'b0;
            done_p1 <= 1'b0;
            if (acc_p0 && col_cnt[0] && row_cnt[0]) begin
                data_p1 <= res_p0;
                vld_p1  <= 1'b1;
                done_p1 <= last_col_p0 & last_row_p0;
            end
        end
    end

    assign pool_data_out       = data_p1;
    assign pool_data_out_valid = vld_p1;
    assign frame_done          = done_p1;

endmodule

// File: tb/tb_pool1_max2x2.sv
// tb_pool1_max2x2: directed bench for pool1_max2x2 (max mode by default,
// average-mode expectations when POOL1_AVG_EN is defined).
module tb_pool1_max2x2;

    localparam int DATA_W  = 32;
    localparam int IN_COLS = 24;
    localparam int IN_ROWS = 24;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] pool_data_in = '0;
    logic              pool_data_in_valid = 1'b0;
    logic              img_in_en = 1'b0;
    logic [DATA_W-1:0] pool_data_out;
    logic              pool_data_out_valid;
    logic              frame_done;

    pool1_max2x2 #(.DATA_W(DATA_W), .IN_COLS(IN_COLS), .IN_ROWS(IN_ROWS)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .pool_data_in       (pool_data_in),
        .pool_data_in_valid (pool_data_in_valid),
        .img_in_en          (img_in_en),
        .pool_data_out      (pool_data_out),
        .pool_data_out_valid(pool_data_out_valid),
        .frame_done         (frame_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Bench-side tracking of where the next beat lands and what must appear next cycle.
    int          tr = 0, tc = 0;
    int          cur_mode = 0;
    logic        armed = 1'b0;
    logic        pend = 1'b0;
    logic        pend_fd = 1'b0;
    logic [31:0] pend_val = '0;
    logic [31:0] last_exp = '0;
    int          out_cnt = 0;
    int          fd_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (pos r=%0d c=%0d)", tag, got, exp, tr, tc);
        end
    endtask

    // Input pixel for each test pattern.
    // 0 ramp r*24+c, 1 hand windows on row pair 0, 2 all zero, 3 all ones.
    function automatic logic [31:0] pixel(input int mode, input int r, input int c);
        logic [31:0] row0 [8];
        logic [31:0] row1 [8];
        row0 = '{32'd9, 32'd3, 32'd1, 32'd100, 32'd4,  32'd8,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        row1 = '{32'd2, 32'd7, 32'd100, 32'd4, 32'd12, 32'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        case (mode)
            0: return 32'(r * 24 + c);
            1: begin
                if (r == 0 && c < 8) return row0[c];
                if (r == 1 && c < 8) return row1[c];
                return 32'd0;
            end
            2: return 32'd0;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // Hand-derived pooled value for the window whose bottom-right pixel is (r,c).
    function automatic logic [31:0] exp_val(input int mode, input int r, input int c);
        int j;
        j = c / 2;
        case (mode)
`ifdef POOL1_AVG_EN
            0: return 32'((r - 1) * 24 + (c - 1) + 12);
            1: begin
                if (r != 1) return 32'd0;
                case (j)
                    0: return 32'd5;
                    1: return 32'd51;
                    2: return 32'd10;
                    3: return 32'hFFFF_FFFF;
                    default: return 32'd0;
                endcase
            end
`else
            0: return 32'(r * 24 + c);
            1: begin
                if (r != 1) return 32'd0;
                case (j)
                    0: return 32'd9;
                    1: return 32'd100;
                    2: return 32'd17;
                    3: return 32'hFFFF_FFFF;
                    default: return 32'd0;
                endcase
            end
`endif
            2: return 32'd0;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // One clock: check the result of the previous edge, then drive the next inputs.
    task automatic cycle(input logic r_n, input logic e, input logic v, input logic [31:0] d);
        @(negedge clk);
        if (armed) begin
            chk("valid", {63'd0, pool_data_out_valid}, {63'd0, pend});
            chk("frame_done", {63'd0, frame_done}, {63'd0, pend_fd});
            if (pend) begin
                chk("data", {32'd0, pool_data_out}, {32'd0, pend_val});
                last_exp = pend_val;
                out_cnt++;
                if (pend_fd) fd_cnt++;
            end else begin
                chk("hold", {32'd0, pool_data_out}, {32'd0, last_exp});
            end
        end
        rst_n              = r_n;
        img_in_en          = e;
        pool_data_in_valid = v;
        pool_data_in       = d;
        pend    = 1'b0;
        pend_fd = 1'b0;
        if (!r_n) begin
            tr = 0; tc = 0;
            last_exp = '0;
            armed = 1'b1;
        end else if (!e) begin
            tr = 0; tc = 0;
        end else if (v) begin
            if ((tr % 2 == 1) && (tc % 2 == 1)) begin
                pend     = 1'b1;
                pend_val = exp_val(cur_mode, tr, tc);
                pend_fd  = (tr == IN_ROWS - 1) && (tc == IN_COLS - 1);
            end
            if (tc == IN_COLS - 1) begin
                tc = 0;
                tr = (tr == IN_ROWS - 1) ? 0 : tr + 1;
            end else begin
                tc++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
    endtask

    task automatic run_beats(input int mode, input int n, input logic gapped);
        cur_mode = mode;
        for (int k = 0; k < n; k++) begin
            if (gapped) begin
                int g;
                g = $urandom_range(0, 2);
                for (int q = 0; q < g; q++) cycle(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
            end
            cycle(1'b1, 1'b1, 1'b1, pixel(mode, k / IN_COLS, k % IN_COLS));
        end
    endtask

    task automatic frame_counts(input string tag, input int n_out, input int n_fd);
        chk({tag, "_outs"}, 64'(out_cnt), 64'(n_out));
        chk({tag, "_fd"}, 64'(fd_cnt), 64'(n_fd));
        out_cnt = 0;
        fd_cnt  = 0;
    endtask

    localparam int NPIX = IN_COLS * IN_ROWS;
    localparam int NOUT = (IN_COLS / 2) * (IN_ROWS / 2);

    initial begin
        // Reset, then idle with the frame disabled.
        cycle(1'b0, 1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 32'd77);
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b1, 32'd55);
        frame_counts("reset", 0, 0);

        // Continuous ramp frame.
        run_beats(0, NPIX, 1'b0);
        idle(2);
        frame_counts("ramp", NOUT, 1);

        // Same ramp with random input gaps.
        run_beats(0, NPIX, 1'b1);
        idle(2);
        frame_counts("gapped", NOUT, 1);

        // Hand windows, then an all-zero frame.
        run_beats(1, NPIX, 1'b0);
        idle(1);
        frame_counts("windows", NOUT, 1);
        run_beats(2, NPIX, 1'b0);
        idle(1);
        frame_counts("zeros", NOUT, 1);

        // Reset for one cycle mid-frame, then a full ramp frame.
        run_beats(0, 300, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 32'd999);
        idle(1);
        out_cnt = 0; fd_cnt = 0;
        run_beats(0, NPIX, 1'b0);
        idle(2);
        frame_counts("rst_mid", NOUT, 1);

        // Frame enable dropped for three cycles mid-frame, then a full ramp frame.
        run_beats(0, 300, 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b1, 32'd888);
        out_cnt = 0; fd_cnt = 0;
        run_beats(0, NPIX, 1'b0);
        idle(2);
        frame_counts("en_mid", NOUT, 1);

        // Back-to-back frames: ramp then all ones, no gap between them.
        run_beats(0, NPIX, 1'b0);
        run_beats(3, NPIX, 1'b0);
        idle(2);
        frame_counts("b2b", 2 * NOUT, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
